wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register for the 5-stage RV32I core. It selects the writeback result, commits it to the 32-entry integer register file, and serves the two decode-stage read ports with same-cycle write-through bypass. It also exports ResultW for EX-stage forwarding and keeps a committed-write counter for debug and performance monitoring.

---
 rtl/core_pkg.sv | 17 +
 rtl/regfile_2r1w.sv | 53 +++++
 rtl/wb_regfile.sv | 63 ++++++
 tb/tb_wb_regfile.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core types and constants for the writeback stage
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // Writeback result select encodings
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_t;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - integer register file, two combinational reads, one write, write-through bypass
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int NREGS = core_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  reg_idx_t        waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_idx_t        raddr1,
  input  reg_idx_t        raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            commit
);

  // Entry 0 is cleared on reset and never written, so it is a constant zero store.
  logic [XLEN-1:0] regs [NREGS];

  // A write is real only when it targets x1..x31 outside of reset.
  assign commit = we && (waddr != '0) && !rst;

  // Storage update: synchronous clear of every entry, otherwise commit the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: x0 is zero, a same-cycle commit to the read index bypasses storage.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (commit && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (commit && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback result select, register file commit and committed-write counter
module wb_regfile
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int NREGS = core_pkg::NREGS,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic [XLEN-1:0]  AluResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] WriteCount
);

  logic commit;

  // Result select; the reserved code yields zero so a bad decode is visible, not random.
  always_comb begin
    ResultW = '0;
    case (result_src_t'(ResultSrcW))
      RES_ALU:  ResultW = AluResultW;
      RES_MEM:  ResultW = ReadDataW;
      RES_PC4:  ResultW = PCPlus4W;
      default:  ResultW = '0;
    endcase
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (Rs1D),
    .raddr2 (Rs2D),
    .rdata1 (RD1D),
    .rdata2 (RD2D),
    .commit (commit)
  );

  // Committed-write counter, wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteCount <= '0;
    end else if (commit) begin
      WriteCount <= WriteCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
module tb_wb_regfile;

  localparam int K_RD1  = 0;
  localparam int K_RD2  = 1;
  localparam int K_RES  = 2;
  localparam int K_CNT  = 3;
  localparam int K_CNTS = 4;

  logic        clk = 1'b1;
  logic        rst;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] AluResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic [31:0] RD1D, RD2D, ResultW, WriteCount;
  logic [31:0] s_rd1, s_rd2, s_res;
  logic [2:0]  s_cnt;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
    int          due;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  int          cyc;
  int          n_checks;
  int          n_errors;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .AluResultW(AluResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
    .WriteCount(WriteCount)
  );

  // Narrow-counter instance on the same stimulus, used to reach the wrap point quickly.
  wb_regfile #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .AluResultW(AluResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(s_rd1), .RD2D(s_rd2), .ResultW(s_res),
    .WriteCount(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] exp, input int due);
    sb_t e;
    e.tag = tag; e.kind = kind; e.exp = exp; e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD1:   obs = RD1D;
        K_RD2:   obs = RD2D;
        K_RES:   obs = ResultW;
        K_CNT:   obs = WriteCount;
        default: obs = {29'd0, s_cnt};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [1:0] src,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit chk_rd);
    logic [31:0] res;
    logic        cm;
    rst = r; RegWriteW = we; ResultSrcW = src; AluResultW = alu; ReadDataW = mem;
    PCPlus4W = pc4; RdW = rd; Rs1D = rs1; Rs2D = rs2;
    case (src)
      2'b00:   res = alu;
      2'b01:   res = mem;
      2'b10:   res = pc4;
      default: res = 32'h0;
    endcase
    cm = we && (rd != 5'd0) && !r;
    if (we && src == 2'b11)
      $display("WARNING: reserved ResultSrcW with RegWriteW=1 commits 0 to x%0d", rd);
    push("result", K_RES, res, cyc);
    if (chk_rd) begin
      push("rd1", K_RD1, (rs1 == 5'd0) ? 32'h0 : (cm && rs1 == rd) ? res : mregs[rs1], cyc);
      push("rd2", K_RD2, (rs2 == 5'd0) ? 32'h0 : (cm && rs2 == rd) ? res : mregs[rs2], cyc);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      mcnt = 32'h0;
    end else if (cm) begin
      mregs[rd] = res;
      mcnt = mcnt + 1;
    end
    push("count", K_CNT, mcnt, cyc + 1);
    push("count_w3", K_CNTS, {29'd0, mcnt[2:0]}, cyc + 1);
    @(negedge clk);
    drain();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] v,
                    input logic [4:0] rs1, input logic [4:0] rs2);
    step(1'b0, 1'b1, src,
         (src == 2'b00) ? v : 32'h0bad_0001,
         (src == 2'b01) ? v : 32'h0bad_0002,
         (src == 2'b10) ? v : 32'h0bad_0003,
         rd, rs1, rs2, 1'b1);
  endtask

  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
    step(1'b0, 1'b0, 2'b00, 32'h5555_aaaa, 32'h0, 32'h0, 5'd3, rs1, rs2, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; mcnt = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    // Reset for two cycles; storage is unknown before the first clear, so no read checks.
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      push("reset_rd1", K_RD1, 32'h0, cyc);
      push("reset_rd2", K_RD2, 32'h0, cyc);
      push("reset_cnt", K_CNT, 32'h0, cyc);
      idle(5'(i), 5'(31 - i));
    end

    // Result mux and commit
    wr(5'd5, 2'b00, 32'h1234_5678, 5'd0, 5'd0);
    wr(5'd6, 2'b01, 32'hDEAD_BEEF, 5'd5, 5'd0);
    wr(5'd1, 2'b10, 32'h0000_0104, 5'd6, 5'd5);
    push("mux_x5", K_RD1, 32'h1234_5678, cyc);
    push("mux_x6", K_RD2, 32'hDEAD_BEEF, cyc);
    push("mux_cnt", K_CNT, 32'd3, cyc);
    idle(5'd5, 5'd6);
    push("mux_x1", K_RD1, 32'h0000_0104, cyc);
    idle(5'd1, 5'd0);

    // x0 protection
    push("x0_same", K_RD1, 32'h0, cyc);
    wr(5'd0, 2'b00, 32'hFFFF_FFFF, 5'd0, 5'd0);
    push("x0_after", K_RD1, 32'h0, cyc);
    push("x0_cnt", K_CNT, 32'd3, cyc);
    idle(5'd0, 5'd0);

    // Write-through bypass on both ports
    wr(5'd7, 2'b00, 32'h11, 5'd0, 5'd0);
    push("byp_rd1", K_RD1, 32'h22, cyc);
    push("byp_rd2", K_RD2, 32'h22, cyc);
    wr(5'd7, 2'b01, 32'h22, 5'd7, 5'd7);
    push("byp_hold", K_RD1, 32'h22, cyc);
    idle(5'd7, 5'd7);

    // Reserved result select commits zero
    wr(5'd11, 2'b00, 32'h7777_0000, 5'd0, 5'd0);
    step(1'b0, 1'b1, 2'b11, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 5'd11, 5'd0, 5'd0, 1'b1);
    push("rsvd_x11", K_RD1, 32'h0, cyc);
    idle(5'd11, 5'd0);

    // Counter wrap on the narrow instance: all-ones, then one commit
    for (int i = 0; i < 16 && mcnt[2:0] != 3'd7; i++)
      wr(5'd10, 2'b00, 32'h100 + 32'(i), 5'd10, 5'd0);
    push("wrap_pre", K_CNTS, 32'd7, cyc);
    wr(5'd10, 2'b00, 32'h0000_0BEE, 5'd10, 5'd0);
    push("wrap", K_CNTS, 32'd0, cyc);
    idle(5'd10, 5'd0);

    // Reset mid-stream with a concurrent write to x9
    wr(5'd9, 2'b00, 32'h55, 5'd0, 5'd0);
    push("rst_old_x9", K_RD1, 32'h55, cyc);
    step(1'b1, 1'b1, 2'b00, 32'hAB, 32'h0, 32'h0, 5'd9, 5'd9, 5'd7, 1'b1);
    push("rst_x9", K_RD1, 32'h0, cyc);
    push("rst_x7", K_RD2, 32'h0, cyc);
    push("rst_cnt", K_CNT, 32'h0, cyc);
    idle(5'd9, 5'd7);

    @(negedge clk);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
